// File: rtl/decoder_664_seq.sv
// rtl/decoder_664_seq.sv - splits a length/base command into 64-lane beats with thermometer masks
//
// Purpose: accepts one command (element count + word address) at a time and
// emits one beat per 64 elements, each carrying the lane-0 address, an active
// lane count, a thermometer lane mask and a last flag, then pulses done.
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   cmd_valid/cmd_ready    command handshake; cmd_len/cmd_base sampled at acceptance
//   beat_valid/beat_ready  beat handshake
//   beat_addr              address of lane 0 of the current beat
//   beat_mask              lane-enable mask (bit i = lane i)
//   beat_cnt               active lane count 1..64
//   beat_last              final beat of the command
//   busy                   command in progress
//   done                   one-cycle completion pulse
module decoder_664_seq #(
    parameter int LEN_W = 16,
    parameter int LANES = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [LEN_W-1:0] cmd_base,
    output logic             beat_valid,
    input  logic             beat_ready,
    output logic [LEN_W-1:0] beat_addr,
    output logic [63:0]      beat_mask,
    output logic [6:0]       beat_cnt,
    output logic             beat_last,
    output logic             busy,
    output logic             done
);

    localparam logic [LEN_W-1:0] LANES_L = LEN_W'(LANES);
    localparam logic [6:0]       LANES_C = 7'(LANES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [LEN_W-1:0] addr_q, addr_d;
    logic [6:0]       cnt_q, cnt_d;
    logic [63:0]      mask_q, mask_d;
    logic             last_q, last_d;
    logic             load;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        last_d  = last_q;
        load    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_len == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                        rem_d   = cmd_len;
                        addr_d  = cmd_base;
                        load    = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (beat_ready) begin
                    if (last_q) begin
                        state_d = S_DONE;
                    end else begin
                        // Non-last beats always carry a full lane set, and the
                        // address wraps naturally at the field width.
                        rem_d  = rem_q - LEN_W'(cnt_q);
                        addr_d = addr_q + LANES_L;
                        load   = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Beat fields are precomputed from the next remaining count so they
        // come straight out of registers with no bubble between beats.
        if (load) begin
            if (rem_d >= LANES_L) begin
                cnt_d = LANES_C;
            end else begin
                cnt_d = rem_d[6:0];
            end
            last_d = (rem_d <= LANES_L);
            if (cnt_d == LANES_C) begin
                mask_d = '1;
            end else begin
                mask_d = (64'd1 << cnt_d) - 64'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            mask_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            last_q  <= last_d;
        end
    end

    assign cmd_ready  = (state_q == S_IDLE);
    assign beat_valid = (state_q == S_ISSUE);
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign beat_addr  = addr_q;
    assign beat_mask  = mask_q;
    assign beat_cnt   = cnt_q;
    assign beat_last  = last_q;

endmodule

// File: tb/tb_decoder_664_seq.sv
// tb/tb_decoder_664_seq.sv - directed self-checking bench for decoder_664_seq
module tb_decoder_664_seq;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_len;
    logic [15:0] cmd_base;
    logic        beat_valid;
    logic        beat_ready;
    logic [15:0] beat_addr;
    logic [63:0] beat_mask;
    logic [6:0]  beat_cnt;
    logic        beat_last;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

    decoder_664_seq #(.LEN_W(16), .LANES(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_len    (cmd_len),
        .cmd_base   (cmd_base),
        .beat_valid (beat_valid),
        .beat_ready (beat_ready),
        .beat_addr  (beat_addr),
        .beat_mask  (beat_mask),
        .beat_cnt   (beat_cnt),
        .beat_last  (beat_last),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input string tag, input logic [15:0] len, input logic [15:0] base);
        cmd_valid = 1'b1;
        cmd_len   = len;
        cmd_base  = base;
        chk({tag, ".cmd_ready"}, 64'(cmd_ready), 64'd1);
        step();
        // Scramble the command fields after acceptance; they must be ignored.
        cmd_valid = 1'b0;
        cmd_len   = 16'hDEAD;
        cmd_base  = 16'hBEEF;
    endtask

    task automatic beat(input string tag, input logic [15:0] a, input logic [6:0] c,
                        input logic [63:0] m, input logic l);
        chk({tag, ".valid"}, 64'(beat_valid), 64'd1);
        chk({tag, ".addr"},  64'(beat_addr),  64'(a));
        chk({tag, ".cnt"},   64'(beat_cnt),   64'(c));
        chk({tag, ".mask"},  beat_mask,       m);
        chk({tag, ".last"},  64'(beat_last),  64'(l));
        step();
    endtask

    task automatic finish_seq(input string tag);
        chk({tag, ".done_hi"},   64'(done),       64'd1);
        chk({tag, ".noval"},     64'(beat_valid), 64'd0);
        chk({tag, ".busy_hi"},   64'(busy),       64'd1);
        chk({tag, ".rdy_lo"},    64'(cmd_ready),  64'd0);
        step();
        chk({tag, ".done_lo"},   64'(done),       64'd0);
        chk({tag, ".busy_lo"},   64'(busy),       64'd0);
        chk({tag, ".rdy_hi"},    64'(cmd_ready),  64'd1);
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, ".valid"}, 64'(beat_valid), 64'd0);
        chk({tag, ".last"},  64'(beat_last),  64'd0);
        chk({tag, ".done"},  64'(done),       64'd0);
        chk({tag, ".busy"},  64'(busy),       64'd0);
        chk({tag, ".mask"},  beat_mask,       64'd0);
        chk({tag, ".cnt"},   64'(beat_cnt),   64'd0);
        chk({tag, ".addr"},  64'(beat_addr),  64'd0);
    endtask

    initial begin
        int n;
        logic [6:0]  last_cnt;
        logic [15:0] last_addr;

        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_len    = '0;
        cmd_base   = '0;
        beat_ready = 1'b1;

        // Reset state
        step();
        step();
        reset_vals("rst");
        rst_n = 1'b1;
        step();
        chk("rst.cmd_ready", 64'(cmd_ready), 64'd1);

        // len 130, base 0x0100
        offer("c130", 16'd130, 16'h0100);
        beat("c130.b0", 16'h0100, 7'd64, ALL1, 1'b0);
        beat("c130.b1", 16'h0140, 7'd64, ALL1, 1'b0);
        beat("c130.b2", 16'h0180, 7'd2, 64'h3, 1'b1);
        finish_seq("c130");

        // len 64 and len 63
        offer("c64", 16'd64, 16'h0000);
        beat("c64.b0", 16'h0000, 7'd64, ALL1, 1'b1);
        finish_seq("c64");
        offer("c63", 16'd63, 16'h0010);
        beat("c63.b0", 16'h0010, 7'd63, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
        finish_seq("c63");

        // len 0: straight to DONE with no beat
        offer("c0", 16'd0, 16'h1234);
        finish_seq("c0");

        // len 100 with 5 stalled cycles
        beat_ready = 1'b0;
        offer("c100", 16'd100, 16'h0400);
        for (int i = 0; i < 5; i++) begin
            beat("c100.stall", 16'h0400, 7'd64, ALL1, 1'b0);
        end
        beat_ready = 1'b1;
        beat("c100.b0", 16'h0400, 7'd64, ALL1, 1'b0);
        beat("c100.b1", 16'h0440, 7'd36, 64'h0000_000F_FFFF_FFFF, 1'b1);
        finish_seq("c100");

        // len 200 wrapping past 0xFFFF
        offer("c200", 16'd200, 16'hFFC0);
        beat("c200.b0", 16'hFFC0, 7'd64, ALL1, 1'b0);
        beat("c200.b1", 16'h0000, 7'd64, ALL1, 1'b0);
        beat("c200.b2", 16'h0040, 7'd64, ALL1, 1'b0);
        beat("c200.b3", 16'h0080, 7'd8, 64'hFF, 1'b1);
        finish_seq("c200");

        // len 300, reset after the second beat with a command offered under reset
        offer("c300", 16'd300, 16'h0200);
        beat("c300.b0", 16'h0200, 7'd64, ALL1, 1'b0);
        beat("c300.b1", 16'h0240, 7'd64, ALL1, 1'b0);
        rst_n     = 1'b0;
        cmd_valid = 1'b1;
        cmd_len   = 16'd5;
        cmd_base  = 16'h0777;
        step();
        reset_vals("c300.rst");
        cmd_valid = 1'b0;
        rst_n     = 1'b1;
        step();
        reset_vals("c300.post");
        chk("c300.post.rdy", 64'(cmd_ready), 64'd1);

        // len 1 after the aborted command
        offer("c1", 16'd1, 16'h0033);
        beat("c1.b0", 16'h0033, 7'd1, 64'h1, 1'b1);
        finish_seq("c1");

        // len 65535: 1024 beats, last carries 63 lanes at 0xFFC0
        offer("cmax", 16'hFFFF, 16'h0000);
        n         = 0;
        last_cnt  = '0;
        last_addr = '0;
        while (beat_valid && n < 1100) begin
            if (beat_last) begin
                last_cnt  = beat_cnt;
                last_addr = beat_addr;
            end
            n++;
            step();
        end
        chk("cmax.beats", 64'(n), 64'd1024);
        chk("cmax.last_cnt", 64'(last_cnt), 64'd63);
        chk("cmax.last_addr", 64'(last_addr), 64'hFFC0);
        finish_seq("cmax");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
